qspi_mem_responder: RTL and testbench

Synthesizable QSPI target that answers the PSRAM-side command set used by our QSPI memory controller: enter-quad (0x35), quad read (0xEB) and quad write (0x38). It oversamples the external SCK/CS/SD pins with the system clock and turns transfers into accesses on a byte-wide synchronous memory port. It serves as an on-chip RAM stand-in for bring-up and for closed-loop verification of the controller.

---
 rtl/qspi_pkg.sv | 22 ++
 rtl/qspi_pin_sync.sv | 42 ++++
 rtl/qspi_mem_responder.sv | 231 +++++++++++++++++++++++
 tb/tb_qspi_mem_responder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_pkg.sv
// Shared constants and state encoding for the QSPI PSRAM-style memory responder.
package qspi_pkg;

  localparam logic [7:0] CMD_ENTER_QPI  = 8'h35;
  localparam logic [7:0] CMD_QUAD_READ  = 8'hEB;
  localparam logic [7:0] CMD_QUAD_WRITE = 8'h38;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INSTR   = 3'd1,
    ST_ADDR    = 3'd2,
    ST_DUMMY   = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_WR_DATA = 3'd5,
    ST_IGNORE  = 3'd6
  } qspi_rsp_state_e;

  function automatic logic is_quad_cmd(input logic [7:0] cmd);
    return (cmd == CMD_QUAD_READ) || (cmd == CMD_QUAD_WRITE);
  endfunction

endpackage

// File: rtl/qspi_pin_sync.sv
// Two-flop synchronizers for the QSPI pins plus SCK edge detection.
module qspi_pin_sync (
  input  logic       clk_i,
  input  logic       rst_in,
  input  logic       sck_i,
  input  logic       cs_in,
  input  logic [3:0] sd_i,
  output logic       cs_sync_o,
  output logic [3:0] sd_sync_o,
  output logic       sck_rise_o,
  output logic       sck_fall_o
);

  logic [1:0] sck_q;
  logic [1:0] cs_q;
  logic [3:0] sd0_q;
  logic [3:0] sd1_q;
  logic       sck_prev_q;

  // Synchronizer chains; CS idles deasserted (high) out of reset.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      sck_q      <= 2'b00;
      cs_q       <= 2'b11;
      sd0_q      <= 4'h0;
      sd1_q      <= 4'h0;
      sck_prev_q <= 1'b0;
    end else begin
      sck_q      <= {sck_q[0], sck_i};
      cs_q       <= {cs_q[0], cs_in};
      sd0_q      <= sd_i;
      sd1_q      <= sd0_q;
      sck_prev_q <= sck_q[1];
    end
  end

  assign cs_sync_o  = cs_q[1];
  assign sd_sync_o  = sd1_q;
  assign sck_rise_o = sck_q[1] & ~sck_prev_q;
  assign sck_fall_o = ~sck_q[1] & sck_prev_q;

endmodule

// File: rtl/qspi_mem_responder.sv
// QSPI target answering enter-quad / quad read / quad write on a byte-wide memory port.
module qspi_mem_responder
  import qspi_pkg::*;
#(
  parameter int ADDR_W       = 24,
  parameter int DUMMY_CYCLES = 7
) (
  input  logic              clk_i,
  input  logic              rst_in,
  input  logic              sck_i,
  input  logic              cs_in,
  input  logic [3:0]        sd_i,
  output logic [3:0]        sd_o,
  output logic [3:0]        sd_oe_o,
  output logic              qpi_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_adr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i
);

  localparam logic [ADDR_W-1:0] ADR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic        cs_s;
  logic [3:0]  sd_s;
  logic        rise_s;
  logic        fall_s;
  logic [23:0] nxt_shift_s;
  logic [7:0]  instr_s;

  qspi_rsp_state_e   state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [19:0]       shift_q, shift_d;
  logic              is_wr_q, is_wr_d;
  logic              phase_q, phase_d;
  logic [3:0]        hi_q, hi_d;
  logic [3:0]        lo_q, lo_d;
  logic [7:0]        rbuf_q, rbuf_d;
  logic              rd_pend_q;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic              qpi_q, qpi_d;
  logic              cs_prev_q;
  logic [3:0]        sd_q, sd_d;
  logic [3:0]        oe_q, oe_d;
  logic              re_q, re_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] madr_q, madr_d;
  logic [7:0]        wdata_q, wdata_d;

  qspi_pin_sync u_sync (
    .clk_i      (clk_i),
    .rst_in     (rst_in),
    .sck_i      (sck_i),
    .cs_in      (cs_in),
    .sd_i       (sd_i),
    .cs_sync_o  (cs_s),
    .sd_sync_o  (sd_s),
    .sck_rise_o (rise_s),
    .sck_fall_o (fall_s)
  );

  assign nxt_shift_s = {shift_q, sd_s};
  assign instr_s     = {shift_q[6:0], sd_s[0]};

  // Transfer FSM; CS high overrides any SCK event in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    is_wr_d = is_wr_q;
    phase_d = phase_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rbuf_d  = rd_pend_q ? mem_rdata_i : rbuf_q;
    adr_d   = adr_q;
    qpi_d   = qpi_q;
    sd_d    = sd_q;
    oe_d    = oe_q;
    re_d    = 1'b0;
    we_d    = 1'b0;
    madr_d  = madr_q;
    wdata_d = wdata_q;
    if (cs_s) begin
      state_d = ST_IDLE;
      oe_d    = 4'h0;
      phase_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_prev_q) begin
            state_d = ST_INSTR;
            cnt_d   = 8'd7;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_INSTR: begin
          if (rise_s) begin
            shift_d = {shift_q[18:0], sd_s[0]};
            if (cnt_q == 8'd0) begin
              if (instr_s == CMD_ENTER_QPI) begin
                qpi_d   = 1'b1;
                state_d = ST_IGNORE;
              end else if (is_quad_cmd(instr_s) && qpi_q) begin
                state_d = ST_ADDR;
                cnt_d   = 8'd5;
                is_wr_d = (instr_s == CMD_QUAD_WRITE);
              end else begin
                state_d = ST_IGNORE;
              end
            end else begin
              cnt_d = cnt_q - 8'd1;
            end
          end else begin
            state_d = ST_INSTR;
          end
        end
        ST_ADDR: begin
          if (rise_s) begin
            shift_d = nxt_shift_s[19:0];
            if (cnt_q == 8'd0) begin
              adr_d   = nxt_shift_s[ADDR_W-1:0];
              phase_d = 1'b0;
              if (is_wr_q) begin
                state_d = ST_WR_DATA;
              end else begin
                state_d = ST_DUMMY;
                cnt_d   = 8'(DUMMY_CYCLES);
                re_d    = 1'b1;
                madr_d  = nxt_shift_s[ADDR_W-1:0];
              end
            end else begin
              cnt_d = cnt_q - 8'd1;
            end
          end else begin
            state_d = ST_ADDR;
          end
        end
        ST_DUMMY, ST_RD_DATA: begin
          if (fall_s && (state_q == ST_RD_DATA) && phase_q) begin
            sd_d    = lo_q;
            adr_d   = adr_q + ADR_ONE;
            phase_d = 1'b0;
          end else if (fall_s && ((state_q == ST_RD_DATA) || (cnt_q == 8'd0))) begin
            // Launching a high nibble also prefetches the following byte.
            state_d = ST_RD_DATA;
            sd_d    = rbuf_q[7:4];
            lo_d    = rbuf_q[3:0];
            oe_d    = 4'hF;
            re_d    = 1'b1;
            madr_d  = adr_q + ADR_ONE;
            phase_d = 1'b1;
          end else if (rise_s && (state_q == ST_DUMMY) && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
            state_d = state_q;
          end
        end
        ST_WR_DATA: begin
          if (rise_s && !phase_q) begin
            hi_d    = sd_s;
            phase_d = 1'b1;
          end else if (rise_s) begin
            we_d    = 1'b1;
            wdata_d = {hi_q, sd_s};
            madr_d  = adr_q;
            adr_d   = adr_q + ADR_ONE;
            phase_d = 1'b0;
          end else begin
            state_d = ST_WR_DATA;
          end
        end
        ST_IGNORE: state_d = ST_IGNORE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      shift_q   <= 20'h0;
      is_wr_q   <= 1'b0;
      phase_q   <= 1'b0;
      hi_q      <= 4'h0;
      lo_q      <= 4'h0;
      rbuf_q    <= 8'h00;
      rd_pend_q <= 1'b0;
      adr_q     <= '0;
      qpi_q     <= 1'b0;
      cs_prev_q <= 1'b1;
      sd_q      <= 4'h0;
      oe_q      <= 4'h0;
      re_q      <= 1'b0;
      we_q      <= 1'b0;
      madr_q    <= '0;
      wdata_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      is_wr_q   <= is_wr_d;
      phase_q   <= phase_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      rbuf_q    <= rbuf_d;
      rd_pend_q <= re_q;
      adr_q     <= adr_d;
      qpi_q     <= qpi_d;
      cs_prev_q <= cs_s;
      sd_q      <= sd_d;
      oe_q      <= oe_d;
      re_q      <= re_d;
      we_q      <= we_d;
      madr_q    <= madr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign sd_o        = sd_q;
  assign sd_oe_o     = oe_q;
  assign qpi_o       = qpi_q;
  assign mem_re_o    = re_q;
  assign mem_we_o    = we_q;
  assign mem_adr_o   = madr_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_qspi_mem_responder.sv
// Scoreboard bench: a host drives QSPI transfers into a 24-bit and an 8-bit responder.
module tb_qspi_mem_responder;

  localparam int DUMMY = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sck = 1'b0;
  logic cs_n = 1'b1;
  logic [3:0] sd = 4'h0;
  bit sel = 1'b0;

  logic [3:0]  sd24, oe24, sd8, oe8;
  logic        qpi24, re24, we24, qpi8, re8, we8;
  logic [23:0] adr24;
  logic [7:0]  adr8, wd24, wd8;
  logic [7:0]  rd24 = 8'h00;
  logic [7:0]  rd8 = 8'h00;

  logic [7:0]  mem24 [int];
  logic [7:0]  mem8 [256];
  logic [31:0] exp_re[$];
  logic [31:0] exp_we[$];
  logic [3:0]  exp_nib[$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  qspi_mem_responder dut (
    .clk_i(clk), .rst_in(rst_n), .sck_i(sck), .cs_in(cs_n), .sd_i(sd),
    .sd_o(sd24), .sd_oe_o(oe24), .qpi_o(qpi24), .mem_re_o(re24), .mem_we_o(we24),
    .mem_adr_o(adr24), .mem_wdata_o(wd24), .mem_rdata_i(rd24)
  );

  qspi_mem_responder #(.ADDR_W(8)) dut8 (
    .clk_i(clk), .rst_in(rst_n), .sck_i(sck), .cs_in(cs_n), .sd_i(sd),
    .sd_o(sd8), .sd_oe_o(oe8), .qpi_o(qpi8), .mem_re_o(re8), .mem_we_o(we8),
    .mem_adr_o(adr8), .mem_wdata_o(wd8), .mem_rdata_i(rd8)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memories behind both ports: registered read, one-cycle latency.
  always @(posedge clk) begin
    if (re24) rd24 <= mem24.exists(int'(adr24)) ? mem24[int'(adr24)] : 8'h00;
    if (we24) mem24[int'(adr24)] = wd24;
    if (re8) rd8 <= mem8[adr8];
    if (we8) mem8[adr8] = wd8;
  end

  logic [23:0] adr_m;
  logic [7:0]  wd_m;
  assign adr_m = sel ? {16'h0, adr8} : adr24;
  assign wd_m  = sel ? wd8 : wd24;

  // Strobe monitor for the selected responder, sampled mid-cycle.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n) begin
      if (sel ? re8 : re24) begin
        e = (exp_re.size() > 0) ? exp_re.pop_front() : 32'hDEAD_BEEF;
        check_eq("mem_re_adr", {8'h00, adr_m}, e);
      end
      if (sel ? we8 : we24) begin
        e = (exp_we.size() > 0) ? exp_we.pop_front() : 32'hDEAD_BEEF;
        check_eq("mem_we_adr_data", {adr_m, wd_m}, e);
      end
    end
  end

  task automatic cyc(input logic [3:0] d, output logic [3:0] q, output logic [3:0] oe);
    sck = 1'b0;
    sd  = d;
    #40;
    q  = sel ? sd8 : sd24;
    oe = sel ? oe8 : oe24;
    sck = 1'b1;
    #40;
  endtask

  task automatic start_xfer();
    sck  = 1'b0;
    cs_n = 1'b0;
    #40;
  endtask

  task automatic end_xfer();
    cs_n = 1'b1;
    #40;
    sck = 1'b0;
    #40;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    logic [3:0] q, oe;
    for (int i = 7; i >= 0; i--) cyc({3'b000, c[i]}, q, oe);
  endtask

  task automatic send_addr(input logic [23:0] a, input int n);
    logic [3:0] q, oe;
    for (int i = 0; i < n; i++) cyc(a[23-4*i -: 4], q, oe);
  endtask

  task automatic do_read(input logic [23:0] a, input logic [23:0] mask, input int nbytes,
                         input logic [31:0] bytes);
    logic [3:0] q, oe, e;
    logic [7:0] b;
    start_xfer();
    send_cmd(8'hEB);
    exp_re.push_back({8'h00, a & mask});
    for (int k = 0; k < nbytes; k++) begin
      exp_re.push_back({8'h00, (a + 24'(k + 1)) & mask});
      b = bytes[31-8*k -: 8];
      exp_nib.push_back(b[7:4]);
      exp_nib.push_back(b[3:0]);
    end
    send_addr(a, 6);
    repeat (DUMMY) cyc(4'h0, q, oe);
    for (int n = 0; n < 2 * nbytes; n++) begin
      cyc(4'h0, q, oe);
      e = exp_nib.pop_front();
      check_eq("rd_nibble", {28'h0, q}, {28'h0, e});
      check_eq("rd_oe", {28'h0, oe}, 32'hF);
    end
    end_xfer();
  endtask

  initial begin
    logic [3:0] q, oe, oe_acc;
    for (int i = 0; i < 256; i++) mem8[i] = 8'h00;
    #23;
    rst_n = 1'b1;
    #20;
    check_eq("rst_sd_o", {28'h0, sd24}, 32'h0);
    check_eq("rst_sd_oe", {28'h0, oe24}, 32'h0);
    check_eq("rst_qpi", {31'h0, qpi24}, 32'h0);
    check_eq("rst_re", {31'h0, re24}, 32'h0);
    check_eq("rst_we", {31'h0, we24}, 32'h0);
    check_eq("rst_adr", {8'h0, adr24}, 32'h0);
    check_eq("rst_wdata", {24'h0, wd24}, 32'h0);

    // Quad read before quad entry must stay silent.
    start_xfer();
    send_cmd(8'hEB);
    oe_acc = 4'h0;
    repeat (16) begin
      cyc(4'h0, q, oe);
      oe_acc |= oe;
    end
    end_xfer();
    check_eq("noqpi_oe", {28'h0, oe_acc}, 32'h0);
    check_eq("noqpi_qpi", {31'h0, qpi24}, 32'h0);

    start_xfer();
    send_cmd(8'h35);
    end_xfer();
    check_eq("enter_qpi", {31'h0, qpi24}, 32'h1);
    check_eq("enter_qpi8", {31'h0, qpi8}, 32'h1);

    mem24[32'h10] = 8'h11;
    mem24[32'h11] = 8'h22;
    mem24[32'h12] = 8'h33;
    mem24[32'h13] = 8'h44;
    mem24[32'h14] = 8'h55;
    do_read(24'h000010, 24'hFFFFFF, 4, 32'h11223344);

    // Write with a trailing half byte.
    start_xfer();
    send_cmd(8'h38);
    send_addr(24'h000100, 6);
    exp_we.push_back({24'h000100, 8'hAB});
    exp_we.push_back({24'h000101, 8'hCD});
    cyc(4'hA, q, oe);
    cyc(4'hB, q, oe);
    cyc(4'hC, q, oe);
    cyc(4'hD, q, oe);
    cyc(4'hE, q, oe);
    end_xfer();
    check_eq("wr_no_third_byte", {31'h0, mem24.exists(32'h102)}, 32'h0);

    // Abort after three address nibbles, then a clean read.
    start_xfer();
    send_cmd(8'hEB);
    send_addr(24'h123456, 3);
    end_xfer();
    mem24[32'h200] = 8'h9E;
    mem24[32'h201] = 8'h7F;
    do_read(24'h000200, 24'hFFFFFF, 2, 32'h9E7F0000);

    // Address wrap on the 8-bit responder.
    sel = 1'b1;
    mem8[8'hFF] = 8'h5A;
    mem8[8'h00] = 8'hC3;
    mem8[8'h01] = 8'h00;
    do_read(24'h0000FF, 24'h0000FF, 2, 32'h5AC30000);
    sel = 1'b0;

    // Reset in the middle of read data.
    mem24[32'h300] = 8'hA5;
    start_xfer();
    send_cmd(8'hEB);
    exp_re.push_back(32'h300);
    exp_re.push_back(32'h301);
    send_addr(24'h000300, 6);
    repeat (DUMMY) cyc(4'h0, q, oe);
    cyc(4'h0, q, oe);
    check_eq("rst_rd_nibble", {28'h0, q}, 32'hA);
    check_eq("rst_rd_oe", {28'h0, oe}, 32'hF);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_oe", {28'h0, oe24}, 32'h0);
    check_eq("midrst_qpi", {31'h0, qpi24}, 32'h0);
    cs_n = 1'b1;
    sck  = 1'b0;
    #40;
    rst_n = 1'b1;
    #40;

    check_eq("re_queue_empty", exp_re.size(), 32'h0);
    check_eq("we_queue_empty", exp_we.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
